// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: decode handshake, redirect request and instruction-memory port.
// The fetch stage uses the master view; the surrounding pipeline and memory use the slave view.
interface fetch_stage_if #(
  parameter int PC_WIDTH = 32
);
  logic                stall;
  logic                branch_taken;
  logic [PC_WIDTH-1:0] branch_target;
  logic                imem_en;
  logic [PC_WIDTH-1:0] imem_addr;
  logic [31:0]         imem_rdata;
  logic [31:0]         instruction;
  logic [PC_WIDTH-1:0] pc_d;
  logic                valid_d;
  logic                halted;

  modport master (
    input  stall, branch_taken, branch_target, imem_rdata,
    output imem_en, imem_addr, instruction, pc_d, valid_d, halted
  );

  modport slave (
    output stall, branch_taken, branch_target, imem_rdata,
    input  imem_en, imem_addr, instruction, pc_d, valid_d, halted
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, one-entry skid buffer for decode stalls,
// taken-branch redirect and halt on HALT_WORD.
module fetch_stage #(
  parameter int                  PC_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
  parameter logic [31:0]         HALT_WORD = 32'hFFFF_FFFF
) (
  input logic           clk,
  input logic           rst,
  fetch_stage_if.master bus
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_HOLD,
    S_HALTED
  } state_t;

  localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

  state_t              state, state_nxt;
  logic [PC_WIDTH-1:0] pc_f, pc_f_nxt;
  logic [PC_WIDTH-1:0] pc_r, pc_r_nxt;
  logic [31:0]         skid, skid_nxt;
  logic                presenting;
  logic                is_halt;
  logic                issue;
  logic                redirect;

  // Decode-facing outputs; a redirect kills the presented instruction in the same cycle.
  always_comb begin
    presenting      = (state == S_RUN) || (state == S_HOLD);
    bus.valid_d     = presenting && !bus.branch_taken && !rst;
    bus.instruction = (state == S_HOLD) ? skid : bus.imem_rdata;
    bus.pc_d        = pc_r;
    bus.halted      = (state == S_HALTED) && !rst;
    is_halt         = (bus.instruction == HALT_WORD);
  end

  always_comb begin
    state_nxt = state;
    pc_f_nxt  = pc_f;
    pc_r_nxt  = pc_r;
    skid_nxt  = skid;
    issue     = 1'b0;
    redirect  = 1'b0;

    if (state != S_HALTED && bus.branch_taken) begin
      redirect  = 1'b1;
      state_nxt = S_RUN;
    end else begin
      case (state)
        S_BOOT: begin
          issue     = 1'b1;
          state_nxt = S_RUN;
        end
        S_RUN: begin
          // Memory data is only valid this one cycle, so capture it before stalling.
          if (bus.stall) begin
            skid_nxt  = bus.imem_rdata;
            state_nxt = S_HOLD;
          end else if (is_halt) begin
            state_nxt = S_HALTED;
          end else begin
            issue = 1'b1;
          end
        end
        S_HOLD: begin
          if (!bus.stall) begin
            if (is_halt) begin
              state_nxt = S_HALTED;
            end else begin
              issue     = 1'b1;
              state_nxt = S_RUN;
            end
          end
        end
        default: ;
      endcase
    end

    if (redirect) begin
      pc_r_nxt = bus.branch_target;
      pc_f_nxt = bus.branch_target + PC_ONE;
    end else if (issue) begin
      pc_r_nxt = pc_f;
      pc_f_nxt = pc_f + PC_ONE;
    end

    bus.imem_en   = (issue || redirect) && !rst;
    bus.imem_addr = redirect ? bus.branch_target : pc_f;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_BOOT;
      pc_f  <= RESET_PC;
      pc_r  <= RESET_PC;
      skid  <= '0;
    end else begin
      state <= state_nxt;
      pc_f  <= pc_f_nxt;
      pc_r  <= pc_r_nxt;
      skid  <= skid_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a transaction-level model of "which instruction is presented next"
// drives per-cycle expectations under directed and random stall/redirect/reset traffic.
module tb_fetch_stage;

  logic clk;
  logic rst;
  logic rst4;

  int n_vec;
  int n_err;

  fetch_stage_if #(.PC_WIDTH(32)) bif ();
  fetch_stage_if #(.PC_WIDTH(4))  bif4 ();

  fetch_stage #(.PC_WIDTH(32), .RESET_PC(32'd0), .HALT_WORD(32'hFFFF_FFFF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  fetch_stage #(.PC_WIDTH(4), .RESET_PC(4'd14), .HALT_WORD(32'hFFFF_FFFF)) dut4 (
    .clk (clk),
    .rst (rst4),
    .bus (bif4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] halt_addr;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a == halt_addr) ? 32'hFFFF_FFFF : 32'h100 + a;
  endfunction

  // Synchronous instruction memory; garbage on the read bus whenever no read was issued.
  always @(posedge clk) begin
    bif.imem_rdata  <= bif.imem_en ? word_at(bif.imem_addr) : $urandom;
    bif4.imem_rdata <= bif4.imem_en ? (32'h100 + {28'd0, bif4.imem_addr}) : $urandom;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: boot pending, an instruction presented, its PC, halted.
  bit          m_boot;
  bit          m_have;
  bit          m_halted;
  logic [31:0] m_pc;

  task automatic step(input bit r, input bit s, input bit b, input logic [31:0] t);
    bit          e_valid;
    bit          e_en;
    bit          e_halted;
    bit          take;
    logic [31:0] e_addr;
    rst                = r;
    bif.stall          = s;
    bif.branch_taken   = b;
    bif.branch_target  = t;
    @(negedge clk);
    e_addr = 32'd0;
    if (r) begin
      e_valid  = 1'b0;
      e_en     = 1'b0;
      e_halted = 1'b0;
    end else begin
      e_halted = m_halted;
      e_valid  = m_have && !b && !m_halted;
      take     = e_valid && !s;
      if (m_halted) begin
        e_en = 1'b0;
      end else if (b) begin
        e_en = 1'b1; e_addr = t;
      end else if (m_boot) begin
        e_en = 1'b1; e_addr = 32'd0;
      end else if (take && word_at(m_pc) != 32'hFFFF_FFFF) begin
        e_en = 1'b1; e_addr = m_pc + 32'd1;
      end else begin
        e_en = 1'b0;
      end
    end
    check_eq("valid_d", {31'd0, bif.valid_d}, {31'd0, e_valid});
    check_eq("halted", {31'd0, bif.halted}, {31'd0, e_halted});
    check_eq("imem_en", {31'd0, bif.imem_en}, {31'd0, e_en});
    if (e_en) check_eq("imem_addr", bif.imem_addr, e_addr);
    if (e_valid) begin
      check_eq("pc_d", bif.pc_d, m_pc);
      check_eq("instruction", bif.instruction, word_at(m_pc));
    end
    if (!r && m_boot) check_eq("pc_d_boot", bif.pc_d, 32'd0);

    if (r) begin
      m_boot = 1'b1; m_have = 1'b0; m_halted = 1'b0;
    end else if (m_halted) begin
      m_have = 1'b0;
    end else if (b) begin
      m_boot = 1'b0; m_have = 1'b1; m_pc = t;
    end else if (m_boot) begin
      m_boot = 1'b0; m_have = 1'b1; m_pc = 32'd0;
    end else if (e_valid && !s) begin
      if (word_at(m_pc) == 32'hFFFF_FFFF) begin
        m_halted = 1'b1; m_have = 1'b0;
      end else begin
        m_pc = m_pc + 32'd1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp4;
    n_vec     = 0;
    n_err     = 0;
    halt_addr = 32'hFFFF_0000;
    m_boot    = 1'b1;
    m_have    = 1'b0;
    m_halted  = 1'b0;
    m_pc      = 32'd0;
    rst       = 1'b1;
    rst4      = 1'b1;
    bif.stall = 1'b0; bif.branch_taken = 1'b0; bif.branch_target = '0;
    bif4.stall = 1'b0; bif4.branch_taken = 1'b0; bif4.branch_target = '0;
    @(posedge clk);
    #1;

    // Narrow PC wraps from 15 to 0.
    rst4 = 1'b0;
    @(negedge clk);
    check_eq("w4_valid_boot", {31'd0, bif4.valid_d}, 32'd0);
    check_eq("w4_en_boot", {31'd0, bif4.imem_en}, 32'd1);
    check_eq("w4_addr_boot", {28'd0, bif4.imem_addr}, 32'd14);
    exp4 = 4'd14;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("w4_valid", {31'd0, bif4.valid_d}, 32'd1);
      check_eq("w4_pc", {28'd0, bif4.pc_d}, {28'd0, exp4});
      check_eq("w4_instr", bif4.instruction, 32'h100 + {28'd0, exp4});
      exp4 = exp4 + 4'd1;
    end
    rst4 = 1'b1;

    // Straight-line run.
    step(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0);

    // Stall three cycles while PC 5 is presented, then redirect while PC 7 is stalled.
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 1, 32'h40);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);

    // Redirect during boot.
    step(1, 0, 0, 0);
    step(0, 0, 1, 32'h20);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);

    // Halt at address 3; branches and stalls ignored afterwards; reset restarts.
    halt_addr = 32'd3;
    step(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
    step(0, 0, 1, 32'h10);
    step(0, 1, 1, 32'h11);
    step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);

    // Reset while holding the skid entry.
    halt_addr = 32'hFFFF_0000;
    step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);

    // Random traffic with a reachable halt word.
    halt_addr = 32'd37;
    step(1, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 100) < 1, ($urandom % 100) < 30, ($urandom % 100) < 8, $urandom % 64);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the vector ASIP pipeline, directly upstream of the decode stage. Holds the program counter, issues word addresses to a synchronous instruction memory with one-cycle read latency, and presents each returned instruction with its PC and a valid flag. Absorbs decode back-pressure with a one-entry skid buffer, services taken-branch redirects from downstream, and stops fetching after a HALT word is consumed.

## Interface
- PC_WIDTH, 32: width of PC and instruction-memory word address.
- RESET_PC, 0: first address fetched after reset.
- HALT_WORD, 32'hFFFF_FFFF: instruction encoding that halts fetch once consumed.

- CLK  in  1  clock; all state updates on its rising edge.
- RST  in  1  synchronous, active-high reset.
- STALL  in  1  decode cannot accept the presented instruction this cycle.
- BRANCH_TAKEN  in  1  redirect request from a later stage.
- BRANCH_TARGET  in  PC_WIDTH  redirect word address.
- IMEM_EN  out  1  read strobe; memory returns data the next cycle.
- IMEM_ADDR  out  PC_WIDTH  read word address.
- IMEM_RDATA  in  32  read data, valid only the cycle after an IMEM_EN=1 cycle.
- INSTRUCTION  out  32  instruction to decode (feeds decode's INSTRUCTION input).
- PC_D  out  PC_WIDTH  word address of INSTRUCTION.
- VALID_D  out  1  INSTRUCTION/PC_D are meaningful.
- HALTED  out  1  fetch has stopped on HALT_WORD.

## Operation
- Registers: PC_F (next address to issue), PC_R (address of instruction in flight or held), SKID (32 bits), state.
- States: BOOT, RUN (memory data presented), HOLD (skid data presented), HALTED.
- Consume = VALID_D && !STALL.
- INSTRUCTION = SKID in HOLD, else IMEM_RDATA. PC_D = PC_R. VALID_D = 1 in RUN/HOLD unless BRANCH_TAKEN is high that cycle (forced 0, combinational).
- Issue: IMEM_EN=1, IMEM_ADDR=PC_F; then PC_R<=PC_F, PC_F<=PC_F+1 (wraps mod 2^PC_WIDTH).
- Redirect (BRANCH_TAKEN=1 in BOOT/RUN/HOLD): IMEM_EN=1, IMEM_ADDR=BRANCH_TARGET; PC_R<=BRANCH_TARGET, PC_F<=BRANCH_TARGET+1, state<=RUN. Overrides STALL and halt detection; presented instruction is discarded.
- BOOT: issue, ->RUN.
- RUN: STALL -> SKID<=IMEM_RDATA, no issue, ->HOLD. Consume of HALT_WORD -> no issue, ->HALTED. Otherwise consume, issue, stay RUN.
- HOLD: STALL -> hold everything, IMEM_EN=0. Consume of HALT_WORD -> ->HALTED. Otherwise consume, issue, ->RUN (no bubble).
- HALTED: IMEM_EN=0, VALID_D=0, HALTED=1; BRANCH_TAKEN and STALL ignored; exit only via RST.
- When not issuing, IMEM_ADDR=PC_F and IMEM_EN=0.

## Timing
- RST=1 (synchronous, wins over all inputs): next state BOOT, PC_F<=RESET_PC, SKID<=0. During the reset cycle and BOOT: IMEM_EN=0 in reset cycle, VALID_D=0, HALTED=0, INSTRUCTION=IMEM_RDATA (don't-care), PC_D=RESET_PC after reset.
- First cycle after RST falls: BOOT, IMEM_EN=1 at RESET_PC. Next cycle: VALID_D=1, PC_D=RESET_PC.
- Fetch latency address->presented: 1 cycle. Throughput: 1 instruction/cycle with STALL low.
- Stall entry: no address issued in first stall cycle; skid captured at that edge. Release: held instruction consumed and next address issued in same cycle; new instruction valid next cycle.
- Redirect latency: target instruction presented the cycle after BRANCH_TAKEN; exactly one VALID_D=0 cycle (the BRANCH_TAKEN cycle).
- Reset mid-stall or mid-redirect: skid contents and in-flight data dropped; behaviour identical to cold reset.

## Test plan
- Reset then run, STALL=0, memory word[i]=i+0x100 -> IMEM_ADDR 0,1,2...; VALID_D rises 2 cycles after RST falls; INSTRUCTION 0x100,0x101,... with PC_D 0,1,2 each cycle.
- STALL high 3 cycles while PC_D=5 presented -> INSTRUCTION stays word[5], IMEM_EN=0 for 3 cycles; on release word[5] consumed, word[6] presented next cycle, no duplicate or lost PC.
- BRANCH_TAKEN with target 0x40 while PC_D=7 and STALL=1 -> VALID_D=0 that cycle, IMEM_ADDR=0x40; next cycle PC_D=0x40, VALID_D=1; 7 never consumed.
- HALT_WORD at address 3 -> PC_D 0..3 consumed, HALTED=1 the cycle after 3 consumed, IMEM_EN=0 and VALID_D=0 thereafter; BRANCH_TAKEN ignored; RST restarts at RESET_PC.
- PC_WIDTH=4, start at 14 -> PC_D sequence 14,15,0,1.
- RST asserted during HOLD -> next cycle BOOT, VALID_D=0; fetch resumes at RESET_PC.
